// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add signed multiplier control path.
package mult_pkg;

  localparam int MULT_N_BITS = 8;

  localparam logic FN_ADD = 1'b0;
  localparam logic FN_SUB = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CLRA,
    ADD,
    SHIFT,
    HOLD
  } ctrl_state_t;

endpackage

// File: rtl/mult_control_unit_if.sv
// Strobe bundle between the multiplier controller and its requester/register unit.
interface mult_control_unit_if;

  logic Run;
  logic ClearA_LoadB;
  logic M;
  logic ClearA;
  logic Ld_B;
  logic Ld_XA;
  logic Shift_En;
  logic Fn;
  logic Done;

  modport master (
    output Run, ClearA_LoadB, M,
    input  ClearA, Ld_B, Ld_XA, Shift_En, Fn, Done
  );

  modport slave (
    input  Run, ClearA_LoadB, M,
    output ClearA, Ld_B, Ld_XA, Shift_En, Fn, Done
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop level synchronizer for a single asynchronous input bit.
module sync_2ff (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops
  // sample their pre-edge values and the chain really is two stages deep.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mult_control_unit.sv
// Sequencing FSM for the shift-add signed multiplier: N add/shift pairs per Run press.
// Optional input synchronizers on Run/ClearA_LoadB via MULT_CTRL_INPUT_SYNC_EN.
module mult_control_unit
  import mult_pkg::*;
#(
  parameter int N_BITS = MULT_N_BITS
) (
  input logic                Clk,
  input logic                Reset,
  mult_control_unit_if.slave bus
);

  localparam int              CNT_W    = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);

  ctrl_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             run_i, load_i, run_q, start;
  logic             clear_a, ld_b, ld_xa, shift_en, fn, done;

`ifdef MULT_CTRL_INPUT_SYNC_EN
  sync_2ff u_sync_run  (.Clk(Clk), .Reset(Reset), .d(bus.Run),          .q(run_i));
  sync_2ff u_sync_load (.Clk(Clk), .Reset(Reset), .d(bus.ClearA_LoadB), .q(load_i));
`else
  assign run_i  = bus.Run;
  assign load_i = bus.ClearA_LoadB;
`endif

  // A Run level already high out of reset must be released before it can start a run.
  assign start = run_i & ~run_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      run_q <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      run_q <= run_i;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clear_a   = 1'b0;
    ld_b      = 1'b0;
    ld_xa     = 1'b0;
    shift_en  = 1'b0;
    fn        = FN_ADD;
    done      = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CLRA;
        end else if (load_i && !run_i) begin
          ld_b    = 1'b1;
          clear_a = 1'b1;
        end
      end
      CLRA: begin
        clear_a   = 1'b1;
        cnt_nxt   = '0;
        state_nxt = ADD;
      end
      ADD: begin
        ld_xa     = bus.M;
        fn        = (cnt == CNT_LAST) ? FN_SUB : FN_ADD;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = HOLD;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
          state_nxt = ADD;
        end
      end
      HOLD: begin
        done = 1'b1;
        if (!run_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset only takes effect at the next edge, so the strobes are squashed meanwhile.
  assign bus.ClearA   = clear_a  & ~Reset;
  assign bus.Ld_B     = ld_b     & ~Reset;
  assign bus.Ld_XA    = ld_xa    & ~Reset;
  assign bus.Shift_En = shift_en & ~Reset;
  assign bus.Fn       = fn       & ~Reset;
  assign bus.Done     = done     & ~Reset;

endmodule

// File: tb/tb_mult_control_unit.sv
// Directed self-checking bench for mult_control_unit, with a behavioural register unit
// for the end-to-end product check. Honours MULT_CTRL_INPUT_SYNC_EN.
module tb_mult_control_unit;

`ifdef MULT_CTRL_INPUT_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  mult_control_unit_if bus ();

  mult_control_unit dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural register unit: X:A:B with a 9-bit adder against the switches.
  logic       use_model = 1'b0;
  logic       m_drv     = 1'b0;
  logic [7:0] sw        = 8'h00;
  logic       reg_x     = 1'b0;
  logic [7:0] reg_a     = 8'h00;
  logic [7:0] reg_b     = 8'h00;
  logic [8:0] sum;

  assign sum   = bus.Fn ? ({reg_a[7], reg_a} - {sw[7], sw}) : ({reg_a[7], reg_a} + {sw[7], sw});
  assign bus.M = use_model ? reg_b[0] : m_drv;

  always @(posedge Clk) begin
    if (bus.ClearA) begin
      reg_x <= 1'b0;
      reg_a <= 8'h00;
    end
    if (bus.Ld_B) reg_b <= sw;
    if (bus.Ld_XA) {reg_x, reg_a} <= sum;
    if (bus.Shift_En) begin
      reg_a <= {reg_x, reg_a[7:1]};
      reg_b <= {reg_a[0], reg_b[7:1]};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bus.ClearA, bus.Ld_B, bus.Ld_XA, bus.Shift_En, bus.Fn, bus.Done};
  endfunction

  // Advance to just after the next rising edge; inputs change here, samples at +3.
  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      #3;
      if (bus.Done === 1'b1) got = 1'b1;
      else next_cycle();
    end
    check(tag, got, 1'b1);
  endtask

  // One Run press held 30 cycles; checks every output in every cycle plus pulse totals.
  task automatic do_run(input logic m_val);
    int n_ld, n_sh, n_fn, l;
    logic [5:0] e;
    n_ld = 0; n_sh = 0; n_fn = 0;
    m_drv = m_val;
    for (int r = 0; r < 36; r++) begin
      bus.Run = (r < 30);
      #3;
      l = r - SL;
      e[5] = (l == 1);
      e[4] = 1'b0;
      e[3] = m_val && l >= 2 && l <= 17 && (l % 2 == 0);
      e[2] = l >= 3 && l <= 17 && (l % 2 == 1);
      e[1] = (l == 16);
      e[0] = l >= 18 && r <= 30 + SL;
      check($sformatf("run_m%0d_r%0d", m_val, r), outs(), e);
      if (bus.Ld_XA === 1'b1) n_ld++;
      if (bus.Shift_En === 1'b1) n_sh++;
      if (bus.Fn === 1'b1) n_fn++;
      next_cycle();
    end
    check($sformatf("ld_xa_count_m%0d", m_val), n_ld, m_val ? 8 : 0);
    check($sformatf("shift_count_m%0d", m_val), n_sh, 8);
    check($sformatf("fn_count_m%0d", m_val), n_fn, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] e;
    int l;

    // Reset with a load request present: Mealy paths must stay gated.
    bus.Run = 1'b0;
    bus.ClearA_LoadB = 1'b1;
    next_cycle();
    next_cycle();
    #3;
    check("reset_gated", outs(), 6'b0);
    next_cycle();
    Reset = 1'b0;
    bus.ClearA_LoadB = 1'b0;
    #3;
    check("post_reset_idle", outs(), 6'b0);
    repeat (3) next_cycle();

    // Load request for three cycles in IDLE.
    for (int r = 0; r < 6; r++) begin
      bus.ClearA_LoadB = (r < 3);
      #3;
      e = (r >= SL && r < SL + 3) ? 6'b110000 : 6'b000000;
      check($sformatf("load_r%0d", r), outs(), e);
      next_cycle();
    end

    // Run and load together: Run wins, CLRA entered, no Ld_B.
    m_drv = 1'b0;
    for (int r = 0; r <= SL + 2; r++) begin
      bus.Run = 1'b1;
      bus.ClearA_LoadB = 1'b1;
      #3;
      e = ((r - SL) == 1) ? 6'b100000 : 6'b000000;
      check($sformatf("run_and_load_r%0d", r), outs(), e);
      next_cycle();
    end
    bus.Run = 1'b0;
    bus.ClearA_LoadB = 1'b0;
    wait_done("short_run_done");
    next_cycle();
    #3;
    check("short_run_done_drop", bus.Done, 1'b0);
    repeat (4) next_cycle();

    do_run(1'b1);
    do_run(1'b0);

    // Reset mid-run, Run kept high: no restart until released and pressed again.
    m_drv = 1'b0;
    for (int r = 0; r <= 10 + SL; r++) begin
      bus.Run = 1'b1;
      Reset = (r == 7 + SL);
      #3;
      l = r - SL;
      if (r < 7 + SL) e = {l == 1, 3'b000, l == 16, 1'b0} | {3'b000, l >= 3 && (l % 2 == 1), 2'b00};
      else e = 6'b0;
      check($sformatf("mid_reset_r%0d", r), outs(), e);
      next_cycle();
    end
    Reset = 1'b0;
    bus.Run = 1'b0;
    repeat (4) next_cycle();
    for (int r = 0; r <= SL + 1; r++) begin
      bus.Run = 1'b1;
      #3;
      e = ((r - SL) == 1) ? 6'b100000 : 6'b000000;
      check($sformatf("restart_r%0d", r), outs(), e);
      next_cycle();
    end
    bus.Run = 1'b0;
    wait_done("restart_done");
    next_cycle();
    repeat (4) next_cycle();

    // End to end: B = 0x07, S = 0xFB -> 7 * -5 = -35 in X:A:B.
    use_model = 1'b1;
    sw = 8'h07;
    bus.ClearA_LoadB = 1'b1;
    next_cycle();
    bus.ClearA_LoadB = 1'b0;
    repeat (4) next_cycle();
    sw = 8'hFB;
    bus.Run = 1'b1;
    wait_done("e2e_done");
    check("e2e_xab", {reg_x, reg_a, reg_b}, 17'h1FFDD);
    next_cycle();
    bus.Run = 1'b0;
    repeat (SL + 2) next_cycle();
    #3;
    check("e2e_done_drop", bus.Done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_control_unit.md
# mult_control_unit

Sequencing FSM for the 8-bit shift-add signed multiplier. It sits directly upstream of the register unit and drives its load, shift and clear strobes. It also drives the add/subtract select of the 9-bit adder that produces the X:A sum. It sequences N add/shift pairs per Run press, subtracting on the final pair for two's-complement correction, then holds until Run is released.

## Interface
- N_BITS, 8: multiplier width; number of add/shift iterations.
- Clk  in  1  system clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high; one clock, no other clock domains.
- Run  in  1  start request, level, active-high (board top inverts buttons).
- ClearA_LoadB  in  1  load-multiplier request, level, active-high.
- M  in  1  current multiplier LSB (B[0] from register unit).
- ClearA  out  1  clear A and X in the register unit.
- Ld_B  out  1  load B from switches.
- Ld_XA  out  1  load adder result into X:A.
- Shift_En  out  1  arithmetic right shift of X:A:B.
- Fn  out  1  adder function: 0 = A+S, 1 = A−S.
- Done  out  1  result valid in X:A:B.

## Operation
- States: IDLE, CLRA, ADD, SHIFT, HOLD. Iteration counter cnt is $clog2(N_BITS) bits wide.
- IDLE:
  - Run=1 → CLRA. ClearA_LoadB is ignored while Run=1.
  - ClearA_LoadB=1 with Run=0 asserts Ld_B and ClearA in the same cycle (Mealy) and stays in IDLE.
- CLRA:
  - Asserts ClearA; cnt ← 0; → ADD.
- ADD:
  - Ld_XA = M (Mealy on M); if M=0, no load occurs.
  - Fn = 1 when cnt == N_BITS−1, else 0. Fn is driven regardless of M.
  - → SHIFT.
- SHIFT:
  - Asserts Shift_En.
  - If cnt == N_BITS−1 → HOLD; else cnt ← cnt+1 and → ADD.
- HOLD:
  - Done=1. Stays while Run=1; Run=0 → IDLE.
- No output is asserted in any state other than those listed. Ld_XA and Shift_En are never asserted in the same cycle.
- Reset:
  - Forces the state to IDLE and cnt to 0 at the next edge, from any state.
  - All outputs are gated to 0 while Reset=1, including the Mealy Ld_B/ClearA paths.
- Reset mid-operation: the sequence is abandoned. Register contents are the register unit's concern.
- Simultaneous Run and ClearA_LoadB in IDLE: Run wins, so no Ld_B.

## Timing
- Reset values: all outputs 0, state IDLE, cnt 0.
- Let t0 be the edge at which Run is sampled high in IDLE (INPUT_SYNC_EN undefined):
  - CLRA during cycle t0+1.
  - ADD k during cycle t0+2+2k; SHIFT k during cycle t0+3+2k, for k = 0..N_BITS−1.
  - For N_BITS=8: Fn=1 only in cycle t0+16; last Shift_En in cycle t0+17; Done from cycle t0+18.
- Total latency from Run to Done: 2·N_BITS+2 cycles.
- Done drops the cycle after Run is sampled low in HOLD.
- Holding Run high does not retrigger a run; a new run requires a release and a new press.
- Mealy outputs (Ld_XA, Ld_B, ClearA in IDLE) follow their inputs combinationally within the cycle. All other outputs decode from registered state only.

## Configuration
- Macro: MULT_CTRL_INPUT_SYNC_EN.
- Defined:
  - Run and ClearA_LoadB each pass through a two-flop synchronizer before use. Synchronizer flops reset to 0.
  - All Run-relative timing shifts by +2 cycles.
  - The IDLE Ld_B/ClearA response lags ClearA_LoadB by 2 cycles.
- Undefined: inputs are used directly (the top must supply synchronous levels). Timing is as stated above.
- M is never synchronized in either case.

## Structure
- Package mult_pkg holds:
  - State enum ctrl_state_t (IDLE, CLRA, ADD, SHIFT, HOLD).
  - Constant MULT_N_BITS = 8.
  - FN_ADD = 1'b0 and FN_SUB = 1'b1.
- Sub-module sync_2ff (1-bit, Clk/Reset), instantiated twice under the macro.
- The FSM (state and counter registers plus output decode) stays in mult_control_unit.

## Test plan
- Reset mid-run: assert Reset at cycle t0+7 → next cycle state IDLE, all outputs 0. With Run held, no restart until Run is released and pressed again.
- M held 1, one Run pulse held 30 cycles:
  - Exactly 8 Ld_XA pulses at t0+2, +4, …, +16 and 8 Shift_En pulses at t0+3, …, +17.
  - Fn=1 only at t0+16.
  - Done=1 from t0+18 until the cycle after Run drops.
- M held 0: zero Ld_XA pulses; Shift_En count is still 8; Fn=1 still at t0+16.
- ClearA_LoadB=1 for 3 cycles in IDLE → Ld_B and ClearA high for exactly those 3 cycles. Run and ClearA_LoadB both high → CLRA entered, Ld_B stays 0.
- End-to-end with the register unit, switches 0x07 × 0xFB (7 × −5) → X:A:B = 0x1FFDD at Done (X=1, A=0xFF, B=0xDD, i.e. −35).
- With MULT_CTRL_INPUT_SYNC_EN defined → the same sequence shifted by exactly 2 cycles, and identical pulse counts.
